// File: rtl/pc_redirect_unit_if.sv
// Fetch-side bus between the branch comparator / instruction memory and the PC redirect unit.
// The master modport is the PC unit; the slave modport is its environment.
interface pc_redirect_unit_if #(
  parameter int unsigned VAR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 branch_taken;
  logic                 jump;
  logic [VAR_WIDTH-1:0] branch_target;
  logic                 stall;
  logic                 imem_ready;
  logic                 imem_req;
  logic [VAR_WIDTH-1:0] imem_addr;
  logic [VAR_WIDTH-1:0] pc;
  logic [VAR_WIDTH-1:0] pc_plus4;
  logic                 flush;
  logic [CNT_WIDTH-1:0] redirect_count;

  modport master (
    input  branch_taken, jump, branch_target, stall, imem_ready,
    output imem_req, imem_addr, pc, pc_plus4, flush, redirect_count
  );

  modport slave (
    output branch_taken, jump, branch_target, stall, imem_ready,
    input  imem_req, imem_addr, pc, pc_plus4, flush, redirect_count
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC sequencer: advances the PC on accepted fetches, redirects on taken
// branches/jumps with a one-cycle flush, and counts redirects (saturating).
module pc_redirect_unit #(
  parameter int unsigned          VAR_WIDTH = 32,
  parameter logic [VAR_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned          CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pc_redirect_unit_if.master     io_bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [VAR_WIDTH-1:0] ALIGN_MASK = ~VAR_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [VAR_WIDTH-1:0] r_pc;
  logic [VAR_WIDTH-1:0] w_next_pc;
  logic [VAR_WIDTH-1:0] w_pc_plus4;
  logic [VAR_WIDTH-1:0] w_target;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_imem_req;
  logic                 r_flush;
  logic                 w_redirect;
  logic                 w_cnt_inc;

  assign w_redirect = io_bus.branch_taken | io_bus.jump;
  assign w_target   = io_bus.branch_target & ALIGN_MASK;
  assign w_pc_plus4 = r_pc + VAR_WIDTH'(4);

  // Next state / next PC; redirect outranks stall and memory ready
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_redirect) begin
          w_next_pc    = w_target;
          w_next_state = ST_FLUSH;
          w_cnt_inc    = 1'b1;
        end else if (!io_bus.stall && io_bus.imem_ready) begin
          w_next_pc = w_pc_plus4;
        end
      end
      ST_FLUSH: begin
        if (w_redirect) begin
          w_next_pc = w_target;
          w_cnt_inc = 1'b1;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      default: begin
        w_next_state = ST_BOOT;
      end
    endcase
  end

  // Request and flush are registered and track the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_imem_req <= 1'b0;
      r_flush    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_imem_req <= (w_next_state == ST_FETCH);
      r_flush    <= (w_next_state == ST_FLUSH);
      if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign io_bus.imem_req       = r_imem_req;
  assign io_bus.imem_addr      = r_pc;
  assign io_bus.pc             = r_pc;
  assign io_bus.pc_plus4       = w_pc_plus4;
  assign io_bus.flush          = r_flush;
  assign io_bus.redirect_count = r_cnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: sequential fetch, back-pressure, redirects,
// wrap, reset mid-flush, and counter saturation on a narrow-counter instance.
module tb_pc_redirect_unit;

  logic clk;
  logic rst;
  logic rst_s;
  int   n_tests;
  int   n_fail;

  pc_redirect_unit_if #(.VAR_WIDTH(32), .CNT_WIDTH(16)) bus ();
  pc_redirect_unit_if #(.VAR_WIDTH(32), .CNT_WIDTH(2))  bus_s ();

  pc_redirect_unit #(.VAR_WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(16)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  pc_redirect_unit #(.VAR_WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(2)) u_dut_sat (
    .clk    (clk),
    .rst    (rst_s),
    .io_bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the fetch-side view of the main instance
  task automatic check_fetch(input string tag, input logic [31:0] addr);
    check({tag, "_req"},   32'(bus.imem_req), 32'd1);
    check({tag, "_addr"},  bus.imem_addr, addr);
    check({tag, "_pc"},    bus.pc, addr);
    check({tag, "_plus4"}, bus.pc_plus4, addr + 32'd4);
    check({tag, "_flush"}, 32'(bus.flush), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    rst_s = 1'b1;
    bus.branch_taken    = 1'b0;
    bus.jump            = 1'b0;
    bus.branch_target   = 32'h0;
    bus.stall           = 1'b0;
    bus.imem_ready      = 1'b1;
    bus_s.branch_taken  = 1'b0;
    bus_s.jump          = 1'b0;
    bus_s.branch_target = 32'h0;
    bus_s.stall         = 1'b0;
    bus_s.imem_ready    = 1'b0;

    step();
    step();
    check("rst_pc",    bus.pc, 32'h0);
    check("rst_req",   32'(bus.imem_req), 32'd0);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_cnt",   32'(bus.redirect_count), 32'd0);

    // Release: BOOT cycle visible now, then sequential fetch
    rst = 1'b0;
    check("boot_req", 32'(bus.imem_req), 32'd0);
    step();
    check_fetch("seq0", 32'h0);
    step();
    check_fetch("seq4", 32'h4);
    step();
    check_fetch("seq8", 32'h8);

    // Memory back-pressure holds the request at 0x8
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_fetch("bp_hold", 32'h8);
    end
    bus.imem_ready = 1'b1;
    step();
    check_fetch("bp_adv", 32'hC);
    step();
    check_fetch("seq10", 32'h10);

    // Taken branch at 0x10 to 0x40
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    step();
    bus.branch_taken = 1'b0;
    check("br_flush", 32'(bus.flush), 32'd1);
    check("br_req",   32'(bus.imem_req), 32'd0);
    check("br_cnt",   32'(bus.redirect_count), 32'd1);
    step();
    check_fetch("br_tgt", 32'h40);
    step();
    check_fetch("br_next", 32'h44);

    // Jump during stall with misaligned target
    bus.stall         = 1'b1;
    bus.jump          = 1'b1;
    bus.branch_target = 32'h103;
    step();
    bus.jump = 1'b0;
    check("js_flush", 32'(bus.flush), 32'd1);
    check("js_pc",    bus.pc, 32'h100);
    check("js_cnt",   32'(bus.redirect_count), 32'd2);
    step();
    check_fetch("js_fetch", 32'h100);
    step();
    check_fetch("js_stall", 32'h100);
    bus.stall = 1'b0;
    step();
    check_fetch("js_adv", 32'h104);

    // Back-to-back redirects; first has both sources high (single count)
    bus.branch_taken  = 1'b1;
    bus.jump          = 1'b1;
    bus.branch_target = 32'h200;
    step();
    check("bb1_flush", 32'(bus.flush), 32'd1);
    check("bb1_pc",    bus.pc, 32'h200);
    check("bb1_cnt",   32'(bus.redirect_count), 32'd3);
    bus.jump          = 1'b0;
    bus.branch_target = 32'h300;
    step();
    bus.branch_taken = 1'b0;
    check("bb2_flush", 32'(bus.flush), 32'd1);
    check("bb2_req",   32'(bus.imem_req), 32'd0);
    check("bb2_cnt",   32'(bus.redirect_count), 32'd4);
    step();
    check_fetch("bb_resume", 32'h300);

    // PC wrap at the top of the address space
    bus.jump          = 1'b1;
    bus.branch_target = 32'hFFFF_FFFE;
    step();
    bus.jump = 1'b0;
    step();
    check("wrap_pc",    bus.pc, 32'hFFFF_FFFC);
    check("wrap_plus4", bus.pc_plus4, 32'h0);
    step();
    check_fetch("wrap_next", 32'h0);

    // Reset during FLUSH, redirect held high through it and into BOOT
    bus.jump          = 1'b1;
    bus.branch_target = 32'h500;
    step();
    check("mf_flush", 32'(bus.flush), 32'd1);
    rst = 1'b1;
    bus.branch_target = 32'h600;
    step();
    rst = 1'b0;
    check("mf_rst_pc",    bus.pc, 32'h0);
    check("mf_rst_flush", 32'(bus.flush), 32'd0);
    check("mf_rst_req",   32'(bus.imem_req), 32'd0);
    check("mf_rst_cnt",   32'(bus.redirect_count), 32'd0);
    step();
    bus.jump = 1'b0;
    check_fetch("boot_drop", 32'h0);
    check("boot_drop_cnt", 32'(bus.redirect_count), 32'd0);

    // Narrow counter saturates at 3
    rst_s = 1'b0;
    step();
    check("sat_fetch", 32'(bus_s.imem_req), 32'd1);
    bus_s.jump = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_s.branch_target = 32'h1000 + 32'(i) * 32'h10;
      step();
      check("sat_cnt", 32'(bus_s.redirect_count), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    bus_s.jump = 1'b0;
    check("sat_pc", bus_s.pc, 32'h1040);
    step();
    check("sat_hold", 32'(bus_s.redirect_count), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
